// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and status bundle of the universal shift register.
interface univ_shift_reg_if #(parameter int WIDTH = 8);
   localparam int CW = $clog2(WIDTH + 1);
   logic             enable;
   logic [1:0]       mode;
   logic             sr_in;
   logic             sl_in;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] Q_out;
   logic [WIDTH-1:0] Qb_out;
   logic             sr_out;
   logic             sl_out;
   logic [CW-1:0]    shift_cnt;
   logic             full_shift;
   modport master (
      output enable, mode, sr_in, sl_in, d_in,
      input  Q_out, Qb_out, sr_out, sl_out, shift_cnt, full_shift
   );
   modport slave (
      input  enable, mode, sr_in, sl_in, d_in,
      output Q_out, Qb_out, sr_out, sl_out, shift_cnt, full_shift
   );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: hold/shift-right/shift-left/load register with optional rotate,
// registered complement output and a saturating shift counter with full-word pulse.
module univ_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               ROTATE    = 1'b0
) (
   input logic             clock,
   input logic             reset,
   univ_shift_reg_if.slave bus
);
   localparam int            CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
   logic [WIDTH-1:0] q_d, q_q, qb_d, qb_q, shr, shl;
   logic [CW-1:0]    cnt_d, cnt_q;
   logic             full_d, full_q, shift, load;
   always_comb begin
      shr    = {ROTATE ? q_q[0] : bus.sr_in, q_q[WIDTH-1:1]};
      shl    = {q_q[WIDTH-2:0], ROTATE ? q_q[WIDTH-1] : bus.sl_in};
      shift  = bus.enable && (bus.mode[1] ^ bus.mode[0]);
      load   = bus.enable && (bus.mode == 2'b11);
      q_d    = load ? bus.d_in : !shift ? q_q : bus.mode[0] ? shr : shl;
      qb_d   = ~q_d;
      cnt_d  = load ? '0 : (shift && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
      // pulse only on the transition into saturation, never while already saturated
      full_d = shift && (cnt_q == CNT_MAX - 1'b1);
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         q_q    <= RESET_VAL;
         qb_q   <= ~RESET_VAL;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         qb_q   <= qb_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   assign bus.Q_out      = q_q;
   assign bus.Qb_out     = qb_q;
   assign bus.sr_out     = q_q[0];
   assign bus.sl_out     = q_q[WIDTH-1];
   assign bus.shift_cnt  = cnt_q;
   assign bus.full_shift = full_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scoreboard bench for univ_shift_reg, serial (u0) and rotating (u1)
// instances; stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_univ_shift_reg;
   logic       clock = 1'b0, reset = 1'b1, enable = 1'b0, sr_in = 1'b0, sl_in = 1'b0, async_chk = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] d_in = 8'h00;
   int         total = 0, passed = 0;
   typedef struct {
      time        t;
      bit         sel;
      logic [7:0] q;
      logic [3:0] cnt;
      logic       full;
      string      name;
   } exp_t;
   exp_t sb[$];
   always #5 clock = ~clock;
   univ_shift_reg_if #(.WIDTH(8)) b0 ();
   univ_shift_reg_if #(.WIDTH(8)) b1 ();
   assign b0.enable = enable;
   assign b0.mode   = mode;
   assign b0.sr_in  = sr_in;
   assign b0.sl_in  = sl_in;
   assign b0.d_in   = d_in;
   assign b1.enable = enable;
   assign b1.mode   = mode;
   assign b1.sr_in  = sr_in;
   assign b1.sl_in  = sl_in;
   assign b1.d_in   = d_in;
   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .ROTATE(1'b0)) u0 (.clock(clock), .reset(reset), .bus(b0));
   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .ROTATE(1'b1)) u1 (.clock(clock), .reset(reset), .bus(b1));

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
      total++;
      if (got === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, got, req);
   endtask

   task automatic want(input bit s, input logic [7:0] q, input logic [3:0] c, input logic f, input string n);
      sb.push_back('{t: $time, sel: s, q: q, cnt: c, full: f, name: n});
   endtask

   task automatic step(input logic e, input logic [1:0] m, input logic sr, input logic sl, input logic [7:0] d);
      @(negedge clock);
      #1;
      enable = e;
      mode   = m;
      sr_in  = sr;
      sl_in  = sl;
      d_in   = d;
   endtask

   // reset falls and is checked well before the next rising edge
   task automatic async_rst(input string n);
      @(negedge clock);
      #1 enable = 1'b0;
      #1 reset = 1'b0;
      want(0, 8'h00, 4'd0, 1'b0, n);
      #1 async_chk = 1'b1;
      #1 async_chk = 1'b0;
   endtask

   task automatic release_rst();
      @(negedge clock);
      #1;
      reset  = 1'b1;
      enable = 1'b0;
      want(0, 8'h00, 4'd0, 1'b0, "rel");
   endtask

   initial forever begin
      @(negedge clock or posedge async_chk);
      while (sb.size() > 0 && sb[0].t < $time) begin
         exp_t e;
         logic [7:0] q, qb;
         logic [3:0] c;
         logic sr, sl, f;
         e  = sb.pop_front();
         q  = e.sel ? b1.Q_out : b0.Q_out;
         qb = e.sel ? b1.Qb_out : b0.Qb_out;
         sr = e.sel ? b1.sr_out : b0.sr_out;
         sl = e.sel ? b1.sl_out : b0.sl_out;
         c  = e.sel ? b1.shift_cnt : b0.shift_cnt;
         f  = e.sel ? b1.full_shift : b0.full_shift;
         chk({e.name, ".q"}, q, e.q);
         chk({e.name, ".qb"}, qb, ~e.q);
         chk({e.name, ".sr_out"}, {7'd0, sr}, {7'd0, e.q[0]});
         chk({e.name, ".sl_out"}, {7'd0, sl}, {7'd0, e.q[7]});
         chk({e.name, ".cnt"}, {4'd0, c}, {4'd0, e.cnt});
         chk({e.name, ".full"}, {7'd0, f}, {7'd0, e.full});
      end
   end

   initial begin
      logic [7:0] t3[9];
      t3 = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
      #2 reset = 1'b0;
      repeat (2) @(negedge clock);
      #1 reset = 1'b1;
      step(1, 2'b11, 0, 0, 8'h3C); want(0, 8'h3C, 4'd0, 0, "pre_load");
      async_rst("t1_rst");
      step(1, 2'b11, 0, 0, 8'hFF); want(0, 8'h00, 4'd0, 0, "t1_hold");
      release_rst();
      step(1, 2'b11, 0, 0, 8'hA5); want(0, 8'hA5, 4'd0, 0, "t2_load");
      for (int i = 0; i < 9; i++) begin
         step(1, 2'b01, 1, 0, 8'h00);
         want(0, t3[i], 4'(i < 8 ? i + 1 : 8), i == 7, $sformatf("t3_shr%0d", i + 1));
      end
      step(1, 2'b11, 0, 0, 8'h3C); want(0, 8'h3C, 4'd0, 0, "t5_load");
      for (int i = 0; i < 4; i++) begin
         step(0, 2'b11, i[0], ~i[0], 8'hFF);
         want(0, 8'h3C, 4'd0, 0, $sformatf("t5_dis%0d", i));
      end
      step(1, 2'b11, 1, 1, 8'h81); want(1, 8'h81, 4'd0, 0, "t4_rot_ld"); want(0, 8'h81, 4'd0, 0, "t4_ser_ld");
      step(1, 2'b10, 1, 0, 8'h00); want(1, 8'h03, 4'd1, 0, "t4_rot_shl1"); want(0, 8'h02, 4'd1, 0, "t4_ser_shl1");
      step(1, 2'b10, 0, 1, 8'h00); want(1, 8'h06, 4'd2, 0, "t4_rot_shl2"); want(0, 8'h05, 4'd2, 0, "t4_ser_shl2");
      step(1, 2'b11, 0, 1, 8'h81); want(1, 8'h81, 4'd0, 0, "t4_rot_rld"); want(0, 8'h81, 4'd0, 0, "t4_ser_rld");
      step(1, 2'b01, 0, 1, 8'h00); want(1, 8'hC0, 4'd1, 0, "t4_rot_shr"); want(0, 8'h40, 4'd1, 0, "t4_ser_shr");
      step(1, 2'b11, 0, 0, 8'h0F); want(0, 8'h0F, 4'd0, 0, "t6_load");
      step(1, 2'b01, 0, 0, 8'h00); want(0, 8'h07, 4'd1, 0, "t6_shr1");
      step(1, 2'b01, 0, 0, 8'h00); want(0, 8'h03, 4'd2, 0, "t6_shr2");
      step(1, 2'b01, 0, 0, 8'h00); want(0, 8'h01, 4'd3, 0, "t6_shr3");
      async_rst("t6_rst");
      release_rst();
      step(1, 2'b11, 0, 0, 8'h55); want(0, 8'h55, 4'd0, 0, "t6_load55");
      step(1, 2'b01, 0, 0, 8'h00); want(0, 8'h2A, 4'd1, 0, "mix_r");
      step(1, 2'b10, 0, 1, 8'h00); want(0, 8'h55, 4'd2, 0, "mix_l");
      step(1, 2'b01, 1, 0, 8'h00); want(0, 8'hAA, 4'd3, 0, "mix_r2");
      step(1, 2'b00, 1, 1, 8'hFF); want(0, 8'hAA, 4'd3, 0, "mode_hold");
      repeat (3) @(negedge clock);
      #1;
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register: the multi-bit, multi-mode successor of the team's single-bit D flip-flop with true and complement outputs. Supports hold, shift right, shift left and parallel load, with optional rotate. A shift counter flags when a full word has been shifted since the last load. Used as a serialiser/deserialiser and general pipeline register in datapath blocks.

Parameters:
WIDTH, 8, register width in bits; WIDTH >= 2.
RESET_VAL, 0, value loaded into Q_out on reset (WIDTH bits).
ROTATE, 0, 0 = shifts take serial inputs; 1 = shifts wrap the end bit around and ignore serial inputs.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
enable  input  1  1 = execute mode this edge; 0 = hold everything.
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
sr_in  input  1  serial input into MSB on shift right (ROTATE=0).
sl_in  input  1  serial input into LSB on shift left (ROTATE=0).
d_in  input  WIDTH  parallel load data.
Q_out  output  WIDTH  registered state.
Qb_out  output  WIDTH  registered complement of Q_out.
sr_out  output  1  Q_out[0], the bit shifted out on shift right.
sl_out  output  1  Q_out[WIDTH-1], the bit shifted out on shift left.
shift_cnt  output  $clog2(WIDTH+1)  shifts since last load or reset; saturates at WIDTH.
full_shift  output  1  one-cycle pulse when shift_cnt reaches WIDTH.

Behaviour:
- Reset: reset=0 takes effect immediately, with no clock edge required. Q_out=RESET_VAL, Qb_out=~RESET_VAL, shift_cnt=0, full_shift=0. Outputs stay there while reset=0. Normal operation resumes on the first rising edge after reset=1.
- All state updates on the rising clock edge. Latency is 1 cycle from inputs to Q_out/Qb_out.
- Qb_out is its own register, loaded with the complement of the next Q value. Qb_out == ~Q_out in every cycle, including during and after reset.
- sr_out and sl_out are plain wires from Q_out bits; no extra latency.
- enable=0: Q_out, Qb_out and shift_cnt hold; full_shift=0. mode is ignored.
- mode 00 (hold): Q_out and shift_cnt unchanged; full_shift=0.
- mode 01 (shift right): Q <= {sr_in, Q[WIDTH-1:1]}. With ROTATE=1, Q <= {Q[0], Q[WIDTH-1:1]}.
- mode 10 (shift left): Q <= {Q[WIDTH-2:0], sl_in}. With ROTATE=1, Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- mode 11 (load): Q <= d_in; shift_cnt <= 0; full_shift=0.
- shift_cnt increments by 1 on every enabled shift, left or right counted alike, and saturates at WIDTH. Further shifts leave it at WIDTH.
- full_shift is registered. It is 1 for exactly the cycle after the edge on which shift_cnt goes WIDTH-1 -> WIDTH, and 0 otherwise. There is no repeat pulse while saturated; the next pulse requires a load or reset first.
- Mixed directions still count: right, left, right counts 3.
- Reset asserted mid-operation aborts immediately. The count is lost and no full_shift is emitted.

Test Plan (WIDTH=8, RESET_VAL=0):
1. Pull reset low between clock edges -> Q_out=00, Qb_out=FF, shift_cnt=0 immediately, with no clock edge; outputs hold while reset=0.
2. enable=1, mode=11, d_in=A5 -> next edge Q_out=A5, Qb_out=5A, sr_out=1, sl_out=1, shift_cnt=0.
3. From A5: mode=01, sr_in=1 for 9 edges -> after edge 1 Q_out=D2; after edge 8 Q_out=FF and shift_cnt=8; full_shift=1 only in the cycle after edge 8; edge 9 leaves shift_cnt=8 and full_shift=0.
4. ROTATE=1: load 81; shift left -> 03, then 06; reload 81, shift right -> C0; sl_in/sr_in toggled throughout have no effect.
5. Q_out=3C, enable=0, mode=11, d_in=FF for 4 edges -> Q_out stays 3C, Qb_out stays C3, shift_cnt unchanged.
6. Load 0F, shift right 3 times, then reset=0 mid-cycle -> Q_out=00, shift_cnt=0, full_shift=0 immediately; release, load 55 -> Q_out=55, Qb_out=AA on the next edge.
